// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Optional entry parity is enabled by defining INSTMEM_PARITY_EN.
package inst_mem_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned PAR_IN_W = 64;

  // Even-parity bit: stored alongside the word so the XOR over all bits is 0.
  function automatic logic even_parity(input logic [PAR_IN_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x WIDTH single-write, single synchronous-read RAM; contents are not reset.
module inst_mem_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read data only updates on a read, so it holds between fetches.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory for the fetch stage: image streamed in while in LOAD,
// 1-cycle fetches in RUN. Define INSTMEM_PARITY_EN for per-entry parity checking.
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
`ifdef INSTMEM_PARITY_EN
  input  logic              load_par_flip,
`endif
  output logic              load_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              inst_fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef INSTMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  state_e           state_q;
  logic [IDX_W-1:0] load_ptr_q;
  logic             addr_bad_q;
  logic             has_data_q;
  logic             accept_c;
  logic             write_c;
  logic             addr_ok_c;
  logic             par_err_c;
  logic [MEM_W-1:0] wdata_c;
  logic [MEM_W-1:0] rdata;

  assign load_ready  = (state_q == ST_LOAD);
  assign fetch_ready = (state_q == ST_RUN) && !load_en;
  assign accept_c    = fetch_req && fetch_ready;
  assign write_c     = (state_q == ST_LOAD) && load_valid;
  assign addr_ok_c   = (fetch_addr[1:0] == 2'b00) && ((fetch_addr >> 2) < ADDR_W'(DEPTH));

`ifdef INSTMEM_PARITY_EN
  assign wdata_c   = {even_parity(PAR_IN_W'(load_data)) ^ load_par_flip, load_data};
  assign par_err_c = has_data_q && (^rdata);
`else
  assign wdata_c   = load_data;
  assign par_err_c = 1'b0;
`endif

  inst_mem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (write_c),
    .waddr (load_ptr_q),
    .wdata (wdata_c),
    .re    (accept_c),
    .raddr (fetch_addr[IDX_W+1:2]),
    .rdata (rdata)
  );

  // FSM, load pointer and response flags; the RAM read register carries the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      load_ptr_q <= '0;
      inst_valid <= 1'b0;
      addr_bad_q <= 1'b0;
      has_data_q <= 1'b0;
    end else begin
      inst_valid <= accept_c;
      if (accept_c) begin
        addr_bad_q <= !addr_ok_c;
        has_data_q <= 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          if (load_valid) load_ptr_q <= load_ptr_q + IDX_W'(1);
          // Filling the last entry ends the load even without load_done.
          if (load_done || (load_valid && (load_ptr_q == IDX_W'(DEPTH - 1)))) begin
            state_q    <= ST_RUN;
            load_ptr_q <= '0;
          end
        end
        ST_RUN: begin
          if (load_en) begin
            state_q    <= ST_LOAD;
            load_ptr_q <= '0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Faulted or not-yet-fetched responses present a NOP instead of stale RAM data.
  assign inst_fault = addr_bad_q || par_err_c;
  assign inst       = (has_data_q && !inst_fault) ? rdata[DATA_W-1:0] : DATA_W'(INST_NOP);

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Scoreboard bench for inst_mem_loadable: fetch expectations are queued at issue
// and checked by a monitor whenever inst_valid is seen.
module tb_inst_mem_loadable;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic [31:0] inst;
    logic        fault;
  } resp_t;

  logic              clk;
  logic              rst_n;
  logic              load_en;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
`ifdef INSTMEM_PARITY_EN
  logic              load_par_flip;
`endif
  logic              load_ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic              inst_fault;

  resp_t       exp_q [$];
  resp_t       mon_e;
  logic [31:0] ref_mem [DEPTH];
  logic        ref_bad [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;

  inst_mem_loadable #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_en       (load_en),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_done     (load_done),
`ifdef INSTMEM_PARITY_EN
    .load_par_flip (load_par_flip),
`endif
    .load_ready    (load_ready),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ready   (fetch_ready),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_fault    (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is served only for an aligned PC inside the image with intact parity.
  function automatic resp_t model(input logic [31:0] a);
    resp_t r;
    int    w;
    w = int'(a >> 2);
    if ((a % 4 != 0) || (a / 4 >= DEPTH) || ref_bad[w]) begin
      r.inst  = 32'h0;
      r.fault = 1'b1;
    end else begin
      r.inst  = ref_mem[w];
      r.fault = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n words starting at entry 0; base==0 means random data.
  task automatic load_words(input int n, input bit done_last, input int flip_idx,
                            input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = (base == 32'h0) ? $urandom : base + 32'(4 * i);
      load_done  = done_last && (i == n - 1);
`ifdef INSTMEM_PARITY_EN
      load_par_flip = (i == flip_idx);
      ref_bad[i]    = (i == flip_idx);
`endif
      ref_mem[i] = load_data;
      tick();
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
`ifdef INSTMEM_PARITY_EN
    load_par_flip = 1'b0;
`endif
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back(model(a));
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic enter_load();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && inst_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_inst_valid: got inst %h with no fetch outstanding", inst);
      end else begin
        mon_e = exp_q.pop_front();
        chk("inst_data", inst, mon_e.inst);
        chk("inst_fault", 32'(inst_fault), 32'(mon_e.fault));
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          k;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'h0;
      ref_bad[i] = 1'b0;
    end
    rst_n      = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_done  = 1'b0;
`ifdef INSTMEM_PARITY_EN
    load_par_flip = 1'b0;
`endif
    fetch_req  = 1'b0;
    fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_load_ready", 32'(load_ready), 32'd1);
    chk("reset_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("reset_inst_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst", inst, 32'h0);
    chk("reset_inst_fault", 32'(inst_fault), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full image without load_done: filling the last entry switches to RUN.
    load_words(DEPTH, 1'b0, -1, 32'h0);
    chk("full_load_ready", 32'(load_ready), 32'd0);
    chk("full_fetch_ready", 32'(fetch_ready), 32'd1);
    fetch(32'h7C);
    fetch(32'h00);
    fetch(32'h04);

    // 20-word reload ended by load_done; word 20 onward keeps the old image.
    enter_load();
    chk("reload_load_ready", 32'(load_ready), 32'd1);
    chk("reload_fetch_ready", 32'(fetch_ready), 32'd0);
    load_words(20, 1'b1, -1, 32'h3421_0004);
    chk("done_load_ready", 32'(load_ready), 32'd0);
    fetch(32'h00);
    fetch(32'h04);
    fetch(32'h4C);
    fetch(32'h50);

    fetch(32'h06);
    fetch(32'h80);
    fetch(32'h7E);
    fetch(32'hFFFF_FFFC);
    fetch(32'h8000_0000);

    // Back-to-back fetches, one per cycle.
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 32'h08 + 32'(4 * i);
      exp_q.push_back(model(fetch_addr));
      tick();
    end
    fetch_req = 1'b0;

    // Fetch followed immediately by a reload request.
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    exp_q.push_back(model(32'h10));
    tick();
    load_en    = 1'b1;
    fetch_addr = 32'h14;
    #1;
    chk("load_en_fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    load_en   = 1'b0;
    fetch_req = 1'b0;
    chk("load_en_load_ready", 32'(load_ready), 32'd1);
    load_words(3, 1'b1, -1, 32'h0);
    for (int i = 0; i < 5; i++) fetch(32'(4 * i));
    fetch(32'h4C);

    // Random fetches mixed with short reloads.
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        enter_load();
        load_words($urandom_range(1, 6), 1'b1, -1, 32'h0);
      end else if (r < 4) begin
        tick();
      end else begin
        k = $urandom_range(0, 9);
        if (k < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        else if (k == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        else if (k == 8) a = 32'h80 + 32'($urandom_range(0, 255)) * 4;
        else             a = $urandom;
        fetch(a);
      end
    end

    // Reset while a response is pending drops it.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0C;
    tick();
    fetch_req = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_fetch_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fetch_load_ready", 32'(load_ready), 32'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset part-way through a load restarts the pointer at entry 0.
    load_words(5, 1'b0, -1, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_load_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_load_load_ready", 32'(load_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    load_words(2, 1'b1, -1, 32'h0);
    for (int i = 0; i < 6; i++) fetch(32'(4 * i));

`ifdef INSTMEM_PARITY_EN
    enter_load();
    load_words(4, 1'b1, 2, 32'h0);
    fetch(32'h08);
    fetch(32'h04);
    fetch(32'h0C);
    enter_load();
    load_words(4, 1'b1, -1, 32'h0);
    fetch(32'h08);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
